// File: rtl/pc_pkg.sv
// ============================================================================
// Module      : pc_pkg
// Description : Shared constants and load-select encoding for the PC unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    localparam logic [31:0] RESET_VEC_D   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_VEC_D = 32'h0000_4180;
    localparam logic [31:0] IM_BASE_D     = 32'h0000_3000;
    localparam logic [31:0] IM_BYTES_D    = 32'h0000_4000;

    // Listed in descending priority; the top module selects exactly one per cycle.
    typedef enum logic [2:0] {
        LD_RESET = 3'd0,
        LD_EXC   = 3'd1,
        LD_ERET  = 3'd2,
        LD_NPC   = 3'd3,
        LD_HOLD  = 3'd4
    } ld_sel_e;

endpackage : pc_pkg

`default_nettype wire

// File: rtl/pc_addr_check.sv
// ============================================================================
// Module      : pc_addr_check
// Description : Combinational fetch/data address legality check (alignment
//               and memory-window bounds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_addr_check
    import pc_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  IM_BASE  = IM_BASE_D[ADDR_W-1:0],
    parameter logic [ADDR_W-1:0]  IM_BYTES = IM_BYTES_D[ADDR_W-1:0]
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              adel
);

    // One extra bit so BASE+BYTES at the top of the address space cannot wrap.
    localparam logic [ADDR_W:0] C_LO = {1'b0, IM_BASE};
    localparam logic [ADDR_W:0] C_HI = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

    logic [ADDR_W:0] w_addr_x;

    assign w_addr_x = {1'b0, addr};
    assign adel     = (addr[1:0] != 2'b00) || (w_addr_x < C_LO) || (w_addr_x >= C_HI);

endmodule : pc_addr_check

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module      : pc_unit
// Description : IF-stage program counter with exception/ERET redirect,
//               AdEL and delay-slot tags, and fetch/stall event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = RESET_VEC_D[ADDR_W-1:0],
    parameter logic [ADDR_W-1:0] HANDLER_VEC = HANDLER_VEC_D[ADDR_W-1:0],
    parameter logic [ADDR_W-1:0] IM_BASE     = IM_BASE_D[ADDR_W-1:0],
    parameter logic [ADDR_W-1:0] IM_BYTES    = IM_BYTES_D[ADDR_W-1:0],
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] npc,
    input  logic              npc_is_bd,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_adel,
    output logic              pc_bd,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    ld_sel_e           ld_sel;
    logic [ADDR_W-1:0] pc_d,    pc_q;
    logic              bd_d,    bd_q;
    logic              adel_d,  adel_q;
    logic [CNT_W-1:0]  fetch_d, fetch_q;
    logic [CNT_W-1:0]  stall_d, stall_q;

    always_comb begin
        if (reset)         ld_sel = LD_RESET;
        else if (exc_req)  ld_sel = LD_EXC;
        else if (eret_req) ld_sel = LD_ERET;
        else if (en)       ld_sel = LD_NPC;
        else               ld_sel = LD_HOLD;
    end

    always_comb begin
        pc_d    = pc_q;
        bd_d    = bd_q;
        fetch_d = fetch_q;
        stall_d = stall_q;
        case (ld_sel)
            LD_RESET: begin
                pc_d    = RESET_VEC;
                bd_d    = 1'b0;
                fetch_d = '0;
                stall_d = '0;
            end
            LD_EXC: begin
                pc_d = HANDLER_VEC;
                bd_d = 1'b0;
            end
            LD_ERET: begin
                pc_d = epc;
                bd_d = 1'b0;
            end
            LD_NPC: begin
                pc_d    = npc;
                bd_d    = npc_is_bd;
                fetch_d = fetch_q + CNT_W'(1);
            end
            default: begin
                stall_d = stall_q + CNT_W'(1);
            end
        endcase
    end

    // Checking the value being loaded keeps pc_adel aligned with pc; on hold
    // pc_d equals pc_q, so the flag naturally holds too.
    pc_addr_check #(
        .ADDR_W   (ADDR_W),
        .IM_BASE  (IM_BASE),
        .IM_BYTES (IM_BYTES)
    ) u_addr_check (
        .addr (pc_d),
        .adel (adel_d)
    );

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        bd_q    <= bd_d;
        adel_q  <= adel_d;
        fetch_q <= fetch_d;
        stall_q <= stall_d;
    end

    assign pc        = pc_q;
    assign pc_adel   = adel_q;
    assign pc_bd     = bd_q;
    assign fetch_cnt = fetch_q;
    assign stall_cnt = stall_q;

endmodule : pc_unit

`default_nettype wire
